// File: rtl/pc_reg_unit.sv
`default_nettype none
// pc_reg_unit: fetch-stage program counter with stall, redirect, exception
// entry/return (saved EPC), sticky double-fault flag and a terminal halt state.
module pc_reg_unit #(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(16'h0800),
   parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(16'h0002),
   parameter int               INC       = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc,
   input  logic             exc_req,
   input  logic [WIDTH-1:0] exc_pc,
   input  logic             rti,
   input  logic             halt_req,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_seq,
   output logic [WIDTH-1:0] epc,
   output logic             in_exc,
   output logic             halted,
   output logic             double_fault
);

   localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t state;

   // Truncation to WIDTH bits gives the required silent wrap-around.
   assign pc_seq = pc + INC_W;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_RUN;
         pc           <= RESET_VEC;
         epc          <= '0;
         in_exc       <= 1'b0;
         halted       <= 1'b0;
         double_fault <= 1'b0;
      end else if (state == ST_RUN) begin
         if (exc_req) begin
            pc <= EXC_VEC;
            if (!in_exc) begin
               epc    <= exc_pc;
               in_exc <= 1'b1;
            end else begin
               double_fault <= 1'b1;
            end
         end else if (rti && in_exc) begin
            pc     <= epc;
            in_exc <= 1'b0;
         end else if (redirect_valid) begin
            pc <= redirect_pc;
         end else if (halt_req) begin
            state  <= ST_HALT;
            halted <= 1'b1;
         end else if (!stall) begin
            pc <= pc_seq;
         end
      end
      // ST_HALT: everything holds until reset.
   end

endmodule
`default_nettype wire

// File: tb/tb_pc_reg_unit.sv
`default_nettype none
// Bench for pc_reg_unit: table of {stimulus, expected state} records fed
// through a scoreboard queue, plus hand-written halt-hold and 8-bit wrap runs.
module tb_pc_reg_unit;

   logic        clk = 1'b0;
   logic        rst, stall, redirect_valid, exc_req, rti, halt_req;
   logic [15:0] redirect_pc, exc_pc;
   logic [15:0] pc, pc_seq, epc;
   logic        in_exc, halted, double_fault;

   logic       rst8, rv8;
   logic [7:0] rpc8, pc8, pc_seq8, epc8;
   logic       in_exc8, halted8, df8;

   always #5 clk = ~clk;

   pc_reg_unit dut (
      .clk(clk), .rst(rst), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .exc_req(exc_req), .exc_pc(exc_pc), .rti(rti), .halt_req(halt_req),
      .pc(pc), .pc_seq(pc_seq), .epc(epc), .in_exc(in_exc),
      .halted(halted), .double_fault(double_fault)
   );

   pc_reg_unit #(.WIDTH(8), .RESET_VEC(8'h00), .EXC_VEC(8'h02), .INC(2)) dut8 (
      .clk(clk), .rst(rst8), .stall(1'b0),
      .redirect_valid(rv8), .redirect_pc(rpc8),
      .exc_req(1'b0), .exc_pc(8'h00), .rti(1'b0), .halt_req(1'b0),
      .pc(pc8), .pc_seq(pc_seq8), .epc(epc8), .in_exc(in_exc8),
      .halted(halted8), .double_fault(df8)
   );

   typedef struct {
      bit          r, st, rv;
      logic [15:0] rpc;
      bit          ex;
      logic [15:0] xpc;
      bit          rt, hl;
      logic [15:0] e_pc, e_epc;
      bit          e_in, e_halt, e_df;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic vec_t mk(bit r, bit st, bit rv, logic [15:0] rpc, bit ex,
                               logic [15:0] xpc, bit rt, bit hl,
                               logic [15:0] e_pc, logic [15:0] e_epc,
                               bit e_in, bit e_halt, bit e_df);
      vec_t v;
      v.r = r; v.st = st; v.rv = rv; v.rpc = rpc; v.ex = ex; v.xpc = xpc;
      v.rt = rt; v.hl = hl; v.e_pc = e_pc; v.e_epc = e_epc;
      v.e_in = e_in; v.e_halt = e_halt; v.e_df = e_df;
      return v;
   endfunction

   task automatic check16(string name, logic [15:0] act, logic [15:0] req);
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic drive(vec_t v);
      rst = v.r; stall = v.st; redirect_valid = v.rv; redirect_pc = v.rpc;
      exc_req = v.ex; exc_pc = v.xpc; rti = v.rt; halt_req = v.hl;
      exp_q.push_back(v);
   endtask

   task automatic step_and_compare(int idx);
      vec_t e;
      @(posedge clk);
      #1;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL scoreboard_empty at vector %0d", idx);
         return;
      end
      e = exp_q.pop_front();
      check16($sformatf("v%0d pc", idx), pc, e.e_pc);
      check16($sformatf("v%0d pc_seq", idx), pc_seq, e.e_pc + 16'd2);
      check16($sformatf("v%0d epc", idx), epc, e.e_epc);
      check16($sformatf("v%0d in_exc", idx), {15'd0, in_exc}, {15'd0, e.e_in});
      check16($sformatf("v%0d halted", idx), {15'd0, halted}, {15'd0, e.e_halt});
      check16($sformatf("v%0d double_fault", idx), {15'd0, double_fault}, {15'd0, e.e_df});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] exp8[$];
      logic [7:0] e8;
      vec_t       hv;

      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      exc_req = 1'b0; exc_pc = '0; rti = 1'b0; halt_req = 1'b0;
      rst8 = 1'b1; rv8 = 1'b0; rpc8 = '0;

      //             r st rv rpc      ex xpc      rt hl  pc       epc      in h df
      vecs.push_back(mk(1,0,0,16'h0000,0,16'h0000,0,0, 16'h0800,16'h0000,0,0,0));
      vecs.push_back(mk(1,0,0,16'h0000,0,16'h0000,0,0, 16'h0800,16'h0000,0,0,0));
      vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,0, 16'h0802,16'h0000,0,0,0));
      vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,0, 16'h0804,16'h0000,0,0,0));
      vecs.push_back(mk(0,1,0,16'h0000,0,16'h0000,0,0, 16'h0804,16'h0000,0,0,0));
      vecs.push_back(mk(0,1,0,16'h0000,0,16'h0000,0,0, 16'h0804,16'h0000,0,0,0));
      vecs.push_back(mk(0,1,1,16'h1234,0,16'h0000,0,0, 16'h1234,16'h0000,0,0,0));
      vecs.push_back(mk(0,0,1,16'h080E,0,16'h0000,0,0, 16'h080E,16'h0000,0,0,0));
      vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,0, 16'h0810,16'h0000,0,0,0));
      vecs.push_back(mk(0,0,0,16'h0000,1,16'h080E,0,0, 16'h0002,16'h080E,1,0,0));
      vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,0, 16'h0004,16'h080E,1,0,0));
      vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,0, 16'h0006,16'h080E,1,0,0));
      vecs.push_back(mk(0,0,0,16'h0000,1,16'h0004,1,0, 16'h0002,16'h080E,1,0,1));
      vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,1,0, 16'h080E,16'h080E,0,0,1));
      vecs.push_back(mk(0,0,1,16'h0900,0,16'h0000,1,0, 16'h0900,16'h080E,0,0,1));
      vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,1, 16'h0900,16'h080E,0,1,1));
      vecs.push_back(mk(1,0,1,16'h5555,1,16'h7777,0,0, 16'h0800,16'h0000,0,0,0));
      vecs.push_back(mk(0,0,0,16'h0000,1,16'h0802,0,1, 16'h0002,16'h0802,1,0,0));
      vecs.push_back(mk(0,1,0,16'h0000,0,16'h0000,1,0, 16'h0802,16'h0802,0,0,0));
      vecs.push_back(mk(0,0,0,16'h0000,1,16'h1111,0,0, 16'h0002,16'h1111,1,0,0));
      vecs.push_back(mk(1,0,0,16'h0000,0,16'h0000,0,0, 16'h0800,16'h0000,0,0,0));
      vecs.push_back(mk(0,0,1,16'hFFFC,0,16'h0000,0,0, 16'hFFFC,16'h0000,0,0,0));
      vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,0, 16'hFFFE,16'h0000,0,0,0));
      vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,0, 16'h0000,16'h0000,0,0,0));
      vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,0, 16'h0002,16'h0000,0,0,0));

      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         step_and_compare(i);
         // Once halted, hammer the unit with redirect/exception/rti for 10 cycles.
         if (vecs[i].hl && !vecs[i].ex && !vecs[i].r) begin
            for (int k = 0; k < 10; k++) begin
               hv = mk(0, k[0], 1, 16'h0A00 + 16'(k), 1, 16'h0B00 + 16'(k), k[1], 1,
                       16'h0900, 16'h080E, 0, 1, 1);
               drive(hv);
               step_and_compare(100 + k);
            end
         end
      end

      // 8-bit instance: reset, redirect to FC, then free-run through the wrap.
      rst8 = 1'b1; exp8.push_back(8'h00);
      @(posedge clk); #1;
      e8 = exp8.pop_front(); n_vec++;
      check16("w8 reset pc", {8'd0, pc8}, {8'd0, e8});
      check16("w8 reset pc_seq", {8'd0, pc_seq8}, {8'd0, e8 + 8'd2});
      rst8 = 1'b0; rv8 = 1'b1; rpc8 = 8'hFC;
      exp8.push_back(8'hFC);
      @(posedge clk); #1;
      rv8 = 1'b0;
      exp8.push_back(8'hFE);
      exp8.push_back(8'h00);
      for (int k = 0; k < 3; k++) begin
         e8 = exp8.pop_front(); n_vec++;
         check16($sformatf("w8 pc step%0d", k), {8'd0, pc8}, {8'd0, e8});
         check16($sformatf("w8 pc_seq step%0d", k), {8'd0, pc_seq8}, {8'd0, e8 + 8'd2});
         if (k < 2) begin
            @(posedge clk); #1;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
